// File: rtl/mips_pkg.sv
// Definitions shared by the instruction-memory loader and the CPU memory sizing.
package mips_pkg;

   localparam int          IMEM_WORDS  = 512;
   localparam logic [7:0]  LOADER_SYNC = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA_HI,
      DATA_LO,
      CHECK,
      DONE,
      ERROR
   } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream into big-endian 16-bit words,
// writes them into instruction memory, and releases the CPU on a good checksum.
module imem_loader
   import mips_pkg::*;
#(
   parameter int ADDR_W    = 9,
   parameter int MAX_WORDS = IMEM_WORDS
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic [ADDR_W:0]   words_loaded,
   output logic              cpu_run,
   output logic              error
);

   loader_state_t     r_state, w_state_nxt;
   logic              r_in_ready;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [15:0]       r_mem_wdata;
   logic [ADDR_W:0]   r_words;
   logic              r_cpu_run;
   logic              r_error;
   logic [7:0]        r_len_hi;
   logic [15:0]       r_count;
   logic [7:0]        r_hi;
   logic [7:0]        r_csum;

   logic              w_acc;
   logic [15:0]       w_len;
   logic [ADDR_W:0]   w_words_nxt;

   assign in_ready     = r_in_ready;
   assign mem_we       = r_mem_we;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign words_loaded = r_words;
   assign cpu_run      = r_cpu_run;
   assign error        = r_error;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_acc       = in_valid && r_in_ready;
      w_len       = {r_len_hi, in_data};
      w_words_nxt = r_words + 1'b1;
      w_state_nxt = r_state;
      if (w_acc) begin
         case (r_state)
            IDLE:    if (in_data == LOADER_SYNC) w_state_nxt = LEN_HI;
            LEN_HI:  w_state_nxt = LEN_LO;
            LEN_LO: begin
               if (w_len > 16'(MAX_WORDS)) w_state_nxt = ERROR;
               else if (w_len == 16'd0)    w_state_nxt = CHECK;
               else                        w_state_nxt = DATA_HI;
            end
            DATA_HI: w_state_nxt = DATA_LO;
            DATA_LO: w_state_nxt = (16'(w_words_nxt) == r_count) ? CHECK : DATA_HI;
            CHECK:   w_state_nxt = (in_data == r_csum) ? DONE : ERROR;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   // Status outputs are derived from the next state so they rise together with it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_in_ready  <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_words     <= '0;
         r_cpu_run   <= 1'b0;
         r_error     <= 1'b0;
         r_len_hi    <= '0;
         r_count     <= '0;
         r_hi        <= '0;
         r_csum      <= '0;
      end else begin
         r_in_ready <= !(w_state_nxt inside {DONE, ERROR});
         r_cpu_run  <= (w_state_nxt == DONE);
         r_error    <= (w_state_nxt == ERROR);
         r_mem_we   <= 1'b0;
         if (w_acc) begin
            case (r_state)
               LEN_HI: r_len_hi <= in_data;
               LEN_LO: begin
                  r_count <= w_len;
                  r_words <= '0;
                  r_csum  <= '0;
               end
               DATA_HI: begin
                  r_hi   <= in_data;
                  r_csum <= r_csum ^ in_data;
               end
               DATA_LO: begin
                  r_csum      <= r_csum ^ in_data;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_words[ADDR_W-1:0];
                  r_mem_wdata <= {r_hi, in_data};
                  r_words     <= w_words_nxt;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as frames are
// driven and checked against each mem_we pulse.
module tb_imem_loader;

   localparam int ADDR_W = 9;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic [ADDR_W:0]   words_loaded;
   logic              cpu_run;
   logic              error;

   int vectors = 0;
   int errors  = 0;
   logic [ADDR_W+15:0] sb[$];
   logic [15:0]        prog[0:511];

   imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(512)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .words_loaded(words_loaded),
      .cpu_run(cpu_run), .error(error)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (mem_we === 1'b1) begin
         logic [ADDR_W+15:0] exp;
         vectors++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
         end else begin
            exp = sb.pop_front();
            if ({mem_addr, mem_wdata} !== exp) begin
               errors++;
               $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                        mem_addr, mem_wdata, exp[ADDR_W+15:16], exp[15:0]);
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      sb.delete();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   // Called at a negedge; returns at the negedge after the byte is accepted.
   task automatic send_byte(input logic [7:0] b, input int gapmax);
      int g;
      int t;
      g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      in_valid = 1'b0;
      repeat (g) @(negedge clock);
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (in_ready !== 1'b1 && t < 20) begin
         @(negedge clock);
         t++;
      end
      if (t >= 20) begin
         vectors++;
         errors++;
         $display("FAIL accept_timeout: byte %h, in_ready=%b, required 1", b, in_ready);
      end else begin
         @(negedge clock);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int n, input logic [7:0] csum_flip, input int gapmax);
      logic [7:0] cs;
      logic [15:0] nn;
      nn = 16'(n);
      cs = 8'h00;
      send_byte(8'hA5, gapmax);
      send_byte(nn[15:8], gapmax);
      send_byte(nn[7:0], gapmax);
      for (int k = 0; k < n; k++) begin
         cs = cs ^ prog[k][15:8] ^ prog[k][7:0];
         sb.push_back({ADDR_W'(k), prog[k]});
         send_byte(prog[k][15:8], gapmax);
         send_byte(prog[k][7:0], gapmax);
      end
      send_byte(cs ^ csum_flip, gapmax);
   endtask

   task automatic check_status(input string name, input logic exp_run, input logic exp_err,
                               input logic exp_rdy, input int exp_words);
      vectors++;
      if ({cpu_run, error, in_ready} !== {exp_run, exp_err, exp_rdy}) begin
         errors++;
         $display("FAIL %s_status: got run/err/rdy=%b%b%b, required %b%b%b",
                  name, cpu_run, error, in_ready, exp_run, exp_err, exp_rdy);
      end
      vectors++;
      if (words_loaded !== (ADDR_W+1)'(exp_words)) begin
         errors++;
         $display("FAIL %s_words: got %0d, required %0d", name, words_loaded, exp_words);
      end
   endtask

   task automatic drain(input string name);
      repeat (4) @(negedge clock);
      vectors++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_pending: got %0d writes outstanding, required 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      vectors++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, words_loaded, cpu_run, error} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b we=%b addr=%0d data=%h wl=%0d run=%b err=%b, required all 0",
                  in_ready, mem_we, mem_addr, mem_wdata, words_loaded, cpu_run, error);
      end
      reset = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_early: got %b, required 0", in_ready);
      end
      @(negedge clock);
      vectors++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_rise: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_single();
      do_reset();
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      sb.push_back({ADDR_W'(0), 16'h4105});
      send_byte(8'h41, 0);
      send_byte(8'h05, 0);
      check_status("single_pre", 1'b0, 1'b0, 1'b1, 1);
      send_byte(8'h44, 0);
      check_status("single", 1'b1, 1'b0, 1'b0, 1);
      drain("single");
   endtask

   task automatic test_bad_checksum();
      do_reset();
      prog[0] = 16'h4105;
      send_frame(1, 8'h01, 0);
      check_status("badsum", 1'b0, 1'b1, 1'b0, 1);
      drain("badsum");
      check_status("badsum_sticky", 1'b0, 1'b1, 1'b0, 1);
   endtask

   task automatic test_oversize();
      do_reset();
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h01, 0);
      check_status("oversize", 1'b0, 1'b1, 1'b0, 0);
      drain("oversize");
   endtask

   task automatic test_empty();
      do_reset();
      send_frame(0, 8'h00, 0);
      check_status("empty", 1'b1, 1'b0, 1'b0, 0);
      drain("empty");
   endtask

   task automatic test_garbage_gaps();
      logic [15:0] p[9] = '{16'h5100, 16'h5202, 16'h76C0, 16'h8401, 16'h6102,
                            16'h6200, 16'h5100, 16'h5202, 16'h1640};
      do_reset();
      for (int k = 0; k < 9; k++) prog[k] = p[k];
      send_byte(8'h00, 3);
      send_byte(8'hFF, 3);
      check_status("garbage", 1'b0, 1'b0, 1'b1, 0);
      send_frame(9, 8'h00, 4);
      check_status("gaps", 1'b1, 1'b0, 1'b0, 9);
      drain("gaps");
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      for (int k = 0; k < 5; k++) prog[k] = 16'h1000 + 16'(k * 16'h0111);
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      send_byte(8'h05, 0);
      for (int k = 0; k < 3; k++) begin
         sb.push_back({ADDR_W'(k), prog[k]});
         send_byte(prog[k][15:8], 1);
         send_byte(prog[k][7:0], 1);
      end
      send_byte(prog[3][15:8], 0);
      check_status("midload_pre", 1'b0, 1'b0, 1'b1, 3);
      reset = 1'b1;
      #1;
      vectors++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, words_loaded, cpu_run, error} !== '0) begin
         errors++;
         $display("FAIL midload_reset: got rdy=%b we=%b addr=%0d data=%h wl=%0d run=%b err=%b, required all 0",
                  in_ready, mem_we, mem_addr, mem_wdata, words_loaded, cpu_run, error);
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      drain("midload");
      send_frame(5, 8'h00, 2);
      check_status("reload", 1'b1, 1'b0, 1'b0, 5);
      drain("reload");
   endtask

   task automatic test_back_to_back_max();
      do_reset();
      for (int k = 0; k < 512; k++) prog[k] = 16'((k * 16'h3A7) ^ 16'hC35A);
      send_frame(512, 8'h00, 0);
      check_status("max", 1'b1, 1'b0, 1'b0, 512);
      drain("max");
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_single();
      test_bad_checksum();
      test_oversize();
      test_empty();
      test_garbage_gaps();
      test_reset_mid_load();
      test_back_to_back_max();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
